// File: rtl/icache_ctrl.sv
// ============================================================================
// icache_ctrl
// ----------------------------------------------------------------------------
// Direct-mapped instruction-cache controller for the MIPS fetch path.
// Drives one shared index/write pair into an external tag RAM ({valid,tag})
// and an external data RAM (one instruction word per line). Hits are served
// in one cycle, misses are refilled from memory with a single-word request,
// and a flush pulse triggers a sweep that invalidates every line.
//
// Ports
//   clk, rst_n             single rising-edge clock, async active-low reset
//   cpu_req/cpu_addr       fetch request, held until cpu_ready
//   cpu_ready/cpu_data     one-cycle response pulse with the instruction
//   flush/flush_busy       invalidate-all request and sweep-in-progress flag
//   mem_req/mem_addr       refill request, held until mem_ack
//   mem_ack/mem_rdata      refill response pulse and word
//   ram_index/ram_write    shared index and write strobe for both RAMs
//   tag_wdata/tag_rdata    {valid,tag} write and combinational read data
//   data_wdata/data_rdata  instruction write and combinational read data
//   hit_cnt/miss_cnt       wrapping hit and miss statistics
// ============================================================================
module icache_ctrl #(
    parameter int ADDR_W  = 32,
    parameter int INDEX_W = 10,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic                          cpu_req,
    input  logic [ADDR_W-1:0]             cpu_addr,
    output logic                          cpu_ready,
    output logic [DATA_W-1:0]             cpu_data,
    input  logic                          flush,
    output logic                          flush_busy,
    output logic                          mem_req,
    output logic [ADDR_W-1:0]             mem_addr,
    input  logic                          mem_ack,
    input  logic [DATA_W-1:0]             mem_rdata,
    output logic [INDEX_W-1:0]            ram_index,
    output logic                          ram_write,
    output logic [ADDR_W-INDEX_W-2:0]     tag_wdata,
    input  logic [ADDR_W-INDEX_W-2:0]     tag_rdata,
    output logic [DATA_W-1:0]             data_wdata,
    input  logic [DATA_W-1:0]             data_rdata,
    output logic [CNT_W-1:0]              hit_cnt,
    output logic [CNT_W-1:0]              miss_cnt
);

    localparam int TAG_W = ADDR_W - INDEX_W - 2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_MISS,
        S_REFILL,
        S_RESP,
        S_FLUSH
    } state_t;

    state_t               state_q,      state_d;
    logic                 cpu_ready_q,  cpu_ready_d;
    logic [DATA_W-1:0]    cpu_data_q,   cpu_data_d;
    logic                 mem_req_q,    mem_req_d;
    logic [ADDR_W-1:0]    mem_addr_q,   mem_addr_d;
    logic                 ram_write_q,  ram_write_d;
    logic [TAG_W:0]       tag_wdata_q,  tag_wdata_d;
    logic [DATA_W-1:0]    data_wdata_q, data_wdata_d;
    logic                 flush_busy_q, flush_busy_d;
    logic                 flush_pend_q, flush_pend_d;
    logic [INDEX_W-1:0]   sweep_q,      sweep_d;
    logic [CNT_W-1:0]     hit_cnt_q,    hit_cnt_d;
    logic [CNT_W-1:0]     miss_cnt_q,   miss_cnt_d;

    logic [TAG_W-1:0]     cpu_tag;
    logic [INDEX_W-1:0]   cpu_index;
    logic [TAG_W-1:0]     miss_tag;
    logic [INDEX_W-1:0]   miss_index;
    logic                 hit;

    // Byte offset bits carry no information for word fetches.
    logic                 unused_addr_bits;
    assign unused_addr_bits = ^cpu_addr[1:0];

    assign cpu_tag    = cpu_addr[ADDR_W-1:INDEX_W+2];
    assign cpu_index  = cpu_addr[INDEX_W+1:2];
    // The latched miss address doubles as the refill tag/index source.
    assign miss_tag   = mem_addr_q[ADDR_W-1:INDEX_W+2];
    assign miss_index = mem_addr_q[INDEX_W+1:2];

    assign hit = tag_rdata[TAG_W] && (tag_rdata[TAG_W-1:0] == cpu_tag);

    // RAM index: the live request address while idle so the lookup is
    // combinational, the latched line during a miss, the sweep counter
    // during a flush.
    always_comb begin
        ram_index = miss_index;
        unique case (state_q)
            S_IDLE:  ram_index = cpu_index;
            S_FLUSH: ram_index = sweep_q;
            default: ram_index = miss_index;
        endcase
    end

    // Next-state and next-output logic. Pulse-type outputs (cpu_ready,
    // ram_write, flush_busy) and write data default low so they only
    // assert in the cycle a state explicitly requests them.
    always_comb begin
        state_d      = state_q;
        cpu_ready_d  = 1'b0;
        cpu_data_d   = cpu_data_q;
        mem_req_d    = mem_req_q;
        mem_addr_d   = mem_addr_q;
        ram_write_d  = 1'b0;
        tag_wdata_d  = '0;
        data_wdata_d = '0;
        flush_busy_d = 1'b0;
        flush_pend_d = flush_pend_q;
        sweep_d      = sweep_q;
        hit_cnt_d    = hit_cnt_q;
        miss_cnt_d   = miss_cnt_q;

        // A flush arriving mid-transaction is remembered for the next IDLE;
        // one arriving during a sweep is simply absorbed.
        if (flush && (state_q != S_IDLE) && (state_q != S_FLUSH)) begin
            flush_pend_d = 1'b1;
        end

        unique case (state_q)
            S_IDLE: begin
                if (flush || flush_pend_q) begin
                    state_d      = S_FLUSH;
                    flush_busy_d = 1'b1;
                    ram_write_d  = 1'b1;
                    sweep_d      = '0;
                    flush_pend_d = 1'b0;
                end else if (cpu_req) begin
                    if (hit) begin
                        state_d     = S_RESP;
                        cpu_ready_d = 1'b1;
                        cpu_data_d  = data_rdata;
                        hit_cnt_d   = hit_cnt_q + CNT_W'(1);
                    end else begin
                        state_d    = S_MISS;
                        mem_req_d  = 1'b1;
                        mem_addr_d = {cpu_addr[ADDR_W-1:2], 2'b00};
                        miss_cnt_d = miss_cnt_q + CNT_W'(1);
                    end
                end
            end
            S_MISS: begin
                if (mem_ack) begin
                    state_d      = S_REFILL;
                    mem_req_d    = 1'b0;
                    ram_write_d  = 1'b1;
                    tag_wdata_d  = {1'b1, miss_tag};
                    data_wdata_d = mem_rdata;
                    cpu_data_d   = mem_rdata;
                end
            end
            S_REFILL: begin
                state_d     = S_RESP;
                cpu_ready_d = 1'b1;
            end
            S_RESP: begin
                state_d = S_IDLE;
            end
            S_FLUSH: begin
                if (sweep_q == {INDEX_W{1'b1}}) begin
                    state_d = S_IDLE;
                end else begin
                    sweep_d      = sweep_q + INDEX_W'(1);
                    flush_busy_d = 1'b1;
                    ram_write_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // All state and registered outputs. The async reset clears outputs
    // immediately, so an in-flight refill request drops without a clock.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= S_IDLE;
            cpu_ready_q  <= 1'b0;
            cpu_data_q   <= '0;
            mem_req_q    <= 1'b0;
            mem_addr_q   <= '0;
            ram_write_q  <= 1'b0;
            tag_wdata_q  <= '0;
            data_wdata_q <= '0;
            flush_busy_q <= 1'b0;
            flush_pend_q <= 1'b0;
            sweep_q      <= '0;
            hit_cnt_q    <= '0;
            miss_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            cpu_ready_q  <= cpu_ready_d;
            cpu_data_q   <= cpu_data_d;
            mem_req_q    <= mem_req_d;
            mem_addr_q   <= mem_addr_d;
            ram_write_q  <= ram_write_d;
            tag_wdata_q  <= tag_wdata_d;
            data_wdata_q <= data_wdata_d;
            flush_busy_q <= flush_busy_d;
            flush_pend_q <= flush_pend_d;
            sweep_q      <= sweep_d;
            hit_cnt_q    <= hit_cnt_d;
            miss_cnt_q   <= miss_cnt_d;
        end
    end

    assign cpu_ready  = cpu_ready_q;
    assign cpu_data   = cpu_data_q;
    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign ram_write  = ram_write_q;
    assign tag_wdata  = tag_wdata_q;
    assign data_wdata = data_wdata_q;
    assign flush_busy = flush_busy_q;
    assign hit_cnt    = hit_cnt_q;
    assign miss_cnt   = miss_cnt_q;

endmodule

// File: tb/tb_icache_ctrl.sv
// ============================================================================
// tb_icache_ctrl
// ----------------------------------------------------------------------------
// Directed bench for icache_ctrl with behavioural tag/data RAMs attached.
// ============================================================================
module tb_icache_ctrl;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cpu_req;
    logic [31:0]   cpu_addr;
    logic          cpu_ready;
    logic [31:0]   cpu_data;
    logic          flush;
    logic          flush_busy;
    logic          mem_req;
    logic [31:0]   mem_addr;
    logic          mem_ack;
    logic [31:0]   mem_rdata;
    logic [9:0]    ram_index;
    logic          ram_write;
    logic [20:0]   tag_wdata;
    logic [20:0]   tag_rdata;
    logic [31:0]   data_wdata;
    logic [31:0]   data_rdata;
    logic [15:0]   hit_cnt;
    logic [15:0]   miss_cnt;

    logic [20:0]   tag_mem  [1024];
    logic [31:0]   data_mem [1024];

    int checks = 0;
    int errors = 0;

    icache_ctrl dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .cpu_req    (cpu_req),
        .cpu_addr   (cpu_addr),
        .cpu_ready  (cpu_ready),
        .cpu_data   (cpu_data),
        .flush      (flush),
        .flush_busy (flush_busy),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ack    (mem_ack),
        .mem_rdata  (mem_rdata),
        .ram_index  (ram_index),
        .ram_write  (ram_write),
        .tag_wdata  (tag_wdata),
        .tag_rdata  (tag_rdata),
        .data_wdata (data_wdata),
        .data_rdata (data_rdata),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    // Behavioural RAMs: combinational read, tag reads zero during writes.
    assign tag_rdata  = ram_write ? 21'd0 : tag_mem[ram_index];
    assign data_rdata = data_mem[ram_index];

    always @(posedge clk) begin
        if (ram_write) begin
            tag_mem[ram_index]  <= tag_wdata;
            data_mem[ram_index] <= data_wdata;
        end
    end

    // Hard stop in case a sequence never completes.
    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic applyStimulus(input logic req, input logic [31:0] addr,
                                 input logic fl, input logic ack,
                                 input logic [31:0] rdata);
        cpu_req   = req;
        cpu_addr  = addr;
        flush     = fl;
        mem_ack   = ack;
        mem_rdata = rdata;
    endtask

    task automatic checkOutput(input string tag, input logic [63:0] observed,
                               input logic [63:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Advance one clock and settle just after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int  cnt;
        bit  sweep_ok;
        bit  found;

        for (int i = 0; i < 1024; i++) begin
            tag_mem[i]  = '0;
            data_mem[i] = '0;
        end
        rst_n = 1'b0;
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        tick();
        checkOutput("rst_cpu_ready", cpu_ready, 0);
        checkOutput("rst_mem_req", mem_req, 0);
        checkOutput("rst_flush_busy", flush_busy, 0);
        checkOutput("rst_ram_write", ram_write, 0);
        checkOutput("rst_hit_cnt", hit_cnt, 0);
        checkOutput("rst_miss_cnt", miss_cnt, 0);
        rst_n = 1'b1;
        tick();

        // ---- 1: cold miss on 0x1004, ack three cycles into the miss
        $display("[TB] test 1: cold miss");
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t1_mem_req", mem_req, 1);
        checkOutput("t1_mem_addr", mem_addr, 32'h0000_1004);
        checkOutput("t1_miss_cnt", miss_cnt, 1);
        checkOutput("t1_no_ready", cpu_ready, 0);
        tick();
        tick();
        checkOutput("t1_mem_req_held", mem_req, 1);
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        checkOutput("t1_refill_write", ram_write, 1);
        checkOutput("t1_refill_index", ram_index, 1);
        checkOutput("t1_refill_tag", tag_wdata, 21'h10_0001);
        checkOutput("t1_refill_data", data_wdata, 32'hDEAD_BEEF);
        checkOutput("t1_mem_req_drop", mem_req, 0);
        tick();
        checkOutput("t1_ready", cpu_ready, 1);
        checkOutput("t1_data", cpu_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t1_ready_pulse", cpu_ready, 0);
        checkOutput("t1_tag_stored", tag_mem[1], 21'h10_0001);

        // ---- 2: hit on 0x1004
        $display("[TB] test 2: hit");
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t2_ready", cpu_ready, 1);
        checkOutput("t2_data", cpu_data, 32'hDEAD_BEEF);
        checkOutput("t2_no_mem_req", mem_req, 0);
        checkOutput("t2_hit_cnt", hit_cnt, 1);
        checkOutput("t2_miss_cnt", miss_cnt, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        // ---- 3: conflicting tag replaces the line, original then misses
        $display("[TB] test 3: conflict replacement");
        applyStimulus(1'b1, 32'h0000_2004, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t3_mem_req", mem_req, 1);
        checkOutput("t3_mem_addr", mem_addr, 32'h0000_2004);
        checkOutput("t3_miss_cnt", miss_cnt, 2);
        applyStimulus(1'b1, 32'h0000_2004, 1'b0, 1'b1, 32'hCAFE_F00D);
        tick();
        applyStimulus(1'b1, 32'h0000_2004, 1'b0, 1'b0, 32'h0);
        checkOutput("t3_refill_tag", tag_wdata, 21'h10_0002);
        checkOutput("t3_refill_index", ram_index, 1);
        tick();
        checkOutput("t3_ready", cpu_ready, 1);
        checkOutput("t3_data", cpu_data, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t3_remiss_req", mem_req, 1);
        checkOutput("t3_remiss_cnt", miss_cnt, 3);
        checkOutput("t3_remiss_hit_cnt", hit_cnt, 1);
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t3_remiss_data", cpu_data, 32'hDEAD_BEEF);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        // ---- 4: flush from IDLE sweeps every line
        $display("[TB] test 4: flush from idle");
        applyStimulus(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        checkOutput("t4_busy_start", flush_busy, 1);
        cnt      = 0;
        sweep_ok = 1'b1;
        while (flush_busy && cnt < 1100) begin
            if (ram_write !== 1'b1 || ram_index !== cnt[9:0] || tag_wdata !== 21'd0)
                sweep_ok = 1'b0;
            cnt++;
            tick();
        end
        checkOutput("t4_busy_cycles", cnt, 1024);
        checkOutput("t4_sweep_pattern", sweep_ok, 1);
        checkOutput("t4_write_off", ram_write, 0);
        checkOutput("t4_line_invalid", tag_mem[1], 0);
        applyStimulus(1'b1, 32'h0000_2004, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t4_post_flush_miss", mem_req, 1);
        checkOutput("t4_miss_cnt", miss_cnt, 4);
        applyStimulus(1'b1, 32'h0000_2004, 1'b0, 1'b1, 32'hCAFE_F00D);
        tick();
        applyStimulus(1'b1, 32'h0000_2004, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        // ---- 5: flush during MISS is deferred until after the response
        $display("[TB] test 5: flush during miss");
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t5_in_miss", mem_req, 1);
        applyStimulus(1'b1, 32'h0000_1004, 1'b1, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_no_sweep_miss", flush_busy, 0);
        checkOutput("t5_still_miss", mem_req, 1);
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        checkOutput("t5_no_sweep_refill", flush_busy, 0);
        tick();
        checkOutput("t5_ready", cpu_ready, 1);
        checkOutput("t5_no_sweep_resp", flush_busy, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        found = 1'b0;
        for (int i = 0; i < 4 && !found; i++) begin
            tick();
            if (flush_busy === 1'b1) found = 1'b1;
        end
        checkOutput("t5_sweep_started", found, 1);
        cnt = 0;
        while (flush_busy && cnt < 1100) begin
            cnt++;
            tick();
        end
        checkOutput("t5_busy_cycles", cnt, 1024);
        checkOutput("t5_line_invalid", tag_mem[1], 0);

        // ---- 6: async reset mid-miss, RAM contents survive
        $display("[TB] test 6: reset during miss");
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b1, 32'hDEAD_BEEF);
        tick();
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        applyStimulus(1'b1, 32'h0000_2008, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t6_in_miss", mem_req, 1);
        checkOutput("t6_miss_cnt", miss_cnt, 7);
        #3;
        rst_n = 1'b0;
        #1;
        checkOutput("t6_async_mem_req", mem_req, 0);
        checkOutput("t6_async_mem_addr", mem_addr, 0);
        checkOutput("t6_async_ready", cpu_ready, 0);
        checkOutput("t6_async_data", cpu_data, 0);
        checkOutput("t6_async_write", ram_write, 0);
        checkOutput("t6_async_miss_cnt", miss_cnt, 0);
        checkOutput("t6_async_busy", flush_busy, 0);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        rst_n = 1'b1;
        tick();
        applyStimulus(1'b1, 32'h0000_1004, 1'b0, 1'b0, 32'h0);
        tick();
        checkOutput("t6_hit_ready", cpu_ready, 1);
        checkOutput("t6_hit_data", cpu_data, 32'hDEAD_BEEF);
        checkOutput("t6_hit_no_mem", mem_req, 0);
        checkOutput("t6_hit_cnt", hit_cnt, 1);
        applyStimulus(1'b0, 32'h0, 1'b0, 1'b0, 32'h0);
        tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
